button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects rising-edge events from `N_BTN` debounced button lines and serialises them onto one valid/ready event channel, using round-robin arbitration. It sits between the debouncer/one-shot front end and the consuming FSM (menu, counter or display control). It replaces per-button one-shot wiring with a single shared, back-pressurable event port. Held buttons can optionally generate auto-repeat events.

## Interface
- `N_BTN`, default 4: number of button inputs (2..16).
- `REPEAT_DELAY`, default 25_000_000: hold cycles, counted from the rise, before the first auto-repeat.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeats.
- `clk`, input, 1: single clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `btn`, input, `N_BTN`: debounced, clk-synchronous button levels.
- `evt_ready`, input, 1: consumer accepts the event this cycle.
- `evt_valid`, output, 1: event offered.
- `evt_id`, output, `$clog2(N_BTN)`: index of the button that produced the offered event.
- `pending`, output, `N_BTN`: per-button pending-event flags (registered).
- `overrun`, output, 1: one-cycle pulse when an event is lost.

## Operation
- Edge detect:
  - `btn_q` is the registered copy of `btn`.
  - `rise[i] = btn[i] & ~btn_q[i]`.
  - During `rst`, `btn_q <= btn`, so a button held through reset produces no event.
- Pending set/clear:
  - `pending[i]` sets on `rise[i]`, or on a repeat tick when auto-repeat is compiled in.
  - It clears when bit i is loaded into the output register.
  - If a set and a load of the same bit occur in the same cycle, set wins and the bit stays 1.
- Overrun:
  - `overrun` pulses for one cycle when a set event hits a bit that is already 1 and is not being loaded that cycle.
  - The event is dropped.
  - If several bits overrun together, there is still a single pulse.
- FSM, two states:
  - IDLE:
    - When `pending != 0`, pick the first set bit searching upward from `last+1` with wrap-around.
    - Load `evt_id`, clear that pending bit, update `last` to the winner, set `evt_valid` and go to OFFER.
    - Otherwise stay in IDLE with `evt_valid = 0`.
  - OFFER:
    - `evt_valid = 1`; `evt_id` stays stable until accepted.
    - On `evt_valid & evt_ready`, drop `evt_valid` and go to IDLE.
    - Otherwise stay in OFFER.
    - New edges keep accumulating into `pending` while in OFFER.
- Pointer: `last` resets to `N_BTN-1`, so the first search starts at index 0.
- Widths: the id and pointer are `$clog2(N_BTN)` bits. The wrap-around compare is done modulo `N_BTN`, not modulo a power of 2.

## Timing
- Reset values:
  - `evt_valid=0`, `evt_id=0`, `pending=0`, `overrun=0`.
  - FSM in IDLE, `last=N_BTN-1`, repeat counters 0.
- Event latency, for `btn[i]` first sampled high at edge k with the FSM in IDLE and nothing else pending:
  - `pending[i]=1` after edge k.
  - `evt_valid=1` with `evt_id=i` after edge k+1.
- Throughput: at most one event per 2 cycles (IDLE→OFFER→IDLE).
- Acceptance: with `evt_ready` held at 1, `evt_valid` is high for exactly one cycle per event.
- `overrun` is registered and asserts in the cycle after the offending edge.
- `rst` asserted mid-OFFER:
  - `evt_valid` is 0 after that edge and the event is discarded.
  - `pending` is cleared; `overrun` does not pulse.

## Configuration
- `BTN_EVT_AUTOREPEAT_EN` defined:
  - Each button has a hold counter.
  - The counter clears while `btn[i]=0` and on a rise; it increments each cycle while `btn[i]=1`.
  - A repeat tick fires when the counter reaches `REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles after that while still held.
  - A tick behaves exactly like a rise for pending/overrun purposes.
  - Releasing the button stops ticks immediately.
- Not defined:
  - No counters are instantiated.
  - Only rising edges create events.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Conditions for all scenarios: `N_BTN=4`; scenario 6 additionally uses `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`.

1. `btn=0001` held 10 cycles, `evt_ready=1` → exactly one event, `evt_id=0`; `evt_valid` high 1 cycle, asserted after edge k+1.
2. `btn` goes 0000→1111 in one cycle, `evt_ready=1` → events `evt_id` 0,1,2,3 in order, each 2 cycles apart; `overrun` never pulses.
3. `evt_ready=0`, three separate presses of btn2 → first press offered with `evt_id=2` held stable; second press sets `pending[2]`; third press → `overrun` one-cycle pulse. Then `evt_ready=1` → exactly 2 events total.
4. Last grant id 2, `pending=1001` → next events `evt_id=3`, then `evt_id=0`.
5. `rst` pulsed while `evt_valid=1` and `btn=0010` held → after reset `evt_valid=0` and `pending=0`; no event until btn1 is released and pressed again.
6. btn1 held 20 cycles, `evt_ready=1` → with macro: 4 events for id 1 (rise, plus ticks at hold counts 8, 12, 16); without macro: 1 event.

Source files
------------

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Round-robin serialiser of button rising-edge events onto one
//               valid/ready channel. Optional auto-repeat for held buttons is
//               built when BTN_EVT_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
  parameter int N_BTN         = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [N_BTN-1:0]         pending,
  output logic                     overrun
);

  localparam int c_id_w = $clog2(N_BTN);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_BTN-1:0]    r_btn_q;
  logic [N_BTN-1:0]    r_pending;
  logic                r_overrun;
  logic [c_id_w-1:0]   r_id;
  logic [c_id_w-1:0]   r_last;
  logic [N_BTN-1:0]    w_rise;
  wire  logic [N_BTN-1:0] w_tick;
  logic [N_BTN-1:0]    w_set;
  logic [N_BTN-1:0]    w_load;
  logic [c_id_w-1:0]   w_win;
  logic                w_found;

  assign w_rise = btn & ~r_btn_q;
  assign w_set  = w_rise | w_tick;

`ifdef BTN_EVT_AUTOREPEAT_EN
  localparam int c_cnt_max = REPEAT_DELAY + REPEAT_PERIOD - 1;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_rep
    logic [c_cnt_w-1:0] r_cnt;

    // Once past the first delay the counter cycles DELAY..DELAY+PERIOD-1,
    // so every return to DELAY marks another repeat.
    always_ff @(posedge clk) begin
      if (rst || !btn[i] || w_rise[i]) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_w'(c_cnt_max)) begin
        r_cnt <= c_cnt_w'(REPEAT_DELAY);
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end

    assign w_tick[i] = btn[i] & (r_cnt == c_cnt_w'(REPEAT_DELAY));
  end
`else
  // Repeat timing has no meaning without counters; this folds to zero.
  assign w_tick = {N_BTN{(REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0)}};
`endif

  // Round-robin pick: bits above the last winner first, then wrap to the bottom.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int j = 0; j < N_BTN; j++) begin
      if (!w_found && r_pending[j] && (j > int'(r_last))) begin
        w_found = 1'b1;
        w_win   = c_id_w'(j);
      end
    end
    for (int j = 0; j < N_BTN; j++) begin
      if (!w_found && r_pending[j] && (j <= int'(r_last))) begin
        w_found = 1'b1;
        w_win   = c_id_w'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load[w_win] = 1'b1;
          w_state_nxt   = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_btn_q <= btn;
    if (rst) begin
      r_pending <= '0;
      r_overrun <= 1'b0;
      r_id      <= '0;
      r_last    <= c_id_w'(N_BTN - 1);
    end else begin
      // A set landing on the bit being loaded re-arms it rather than overrunning.
      r_pending <= (r_pending & ~w_load) | w_set;
      r_overrun <= |(w_set & r_pending & ~w_load);
      if (|w_load) begin
        r_id   <= w_win;
        r_last <= w_win;
      end
    end
  end

  assign evt_valid = (r_state == S_OFFER);
  assign evt_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// Bench for button_event_arbiter: cycle model plus directed literal checks.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         evt_ready = 1'b0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic         overrun;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN         (N),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  bit           m_on = 1'b0;
  bit           m_valid;
  int           m_id;
  int           m_last;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_btnq;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_set;
  logic [N-1:0] m_ld;
  logic [1:0]   m_j;
  bit           m_found;
  bit           m_ovr;
`ifdef BTN_EVT_AUTOREPEAT_EN
  int           m_cnt[N];
`endif
  int           dut_q[$];
  int           mdl_q[$];
  int           ovr_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_on    = 1'b1;
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
      m_pend  = '0;
      m_ovr   = 1'b0;
      m_btnq  = btn;
`ifdef BTN_EVT_AUTOREPEAT_EN
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    end else begin
      m_ld = '0;
      for (int i = 0; i < N; i++) begin
        m_rise[i] = btn[i] & ~m_btnq[i];
        m_set[i]  = m_rise[i];
`ifdef BTN_EVT_AUTOREPEAT_EN
        if (btn[i] && m_cnt[i] >= RD && ((m_cnt[i] - RD) % RP) == 0) m_set[i] = 1'b1;
        m_cnt[i] = (btn[i] && !m_rise[i]) ? m_cnt[i] + 1 : 0;
`endif
      end
      if (m_valid) begin
        if (evt_ready) begin
          mdl_q.push_back(m_id);
          m_valid = 1'b0;
        end
      end else if (m_pend != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          m_j = 2'((m_last + k) % N);
          if (!m_found && m_pend[m_j]) begin
            m_found   = 1'b1;
            m_ld[m_j] = 1'b1;
            m_id      = int'(m_j);
            m_last    = int'(m_j);
            m_valid   = 1'b1;
          end
        end
      end
      m_ovr  = |(m_set & m_pend & ~m_ld);
      m_pend = (m_pend & ~m_ld) | m_set;
      m_btnq = btn;
    end
  end

  // DUT-side transaction log (values seen before the edge updates them)
  always @(posedge clk) begin
    if (m_on && !rst) begin
      if (evt_valid && evt_ready) dut_q.push_back(int'(evt_id));
      if (overrun) ovr_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("evt_valid", {31'b0, evt_valid}, {31'b0, m_valid});
      if (m_valid) chk("evt_id", {30'b0, evt_id}, m_id);
      chk("pending", {28'b0, pending}, {28'b0, m_pend});
      chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    btn       = '0;
    evt_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    dut_q.delete();
    mdl_q.delete();
    ovr_cnt = 0;
  endtask

  task automatic chk_log(input string name, input int n_exp,
                         input int id0, input int id1, input int id2, input int id3);
    int ids[4];
    ids[0] = id0; ids[1] = id1; ids[2] = id2; ids[3] = id3;
    chk({name, "_count"}, dut_q.size(), n_exp);
    chk({name, "_model_count"}, mdl_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < 4; k++) begin
      chk({name, "_id"}, (k < dut_q.size()) ? dut_q[k] : -1, ids[k]);
      chk({name, "_model_id"}, (k < mdl_q.size()) ? mdl_q[k] : -1, ids[k]);
    end
  endtask

  initial begin
    cyc(1);
    // 1: single press, latency and one-cycle valid
    do_reset();
    chk("rst_valid", {31'b0, evt_valid}, 0);
    chk("rst_id", {30'b0, evt_id}, 0);
    chk("rst_pending", {28'b0, pending}, 0);
    chk("rst_overrun", {31'b0, overrun}, 0);
    evt_ready = 1'b1;
    btn = 4'b0001;
    cyc(1);
    chk("s1_pend_k", {28'b0, pending}, 32'h1);
    chk("s1_valid_k", {31'b0, evt_valid}, 0);
    cyc(1);
    chk("s1_valid_k1", {31'b0, evt_valid}, 1);
    chk("s1_id_k1", {30'b0, evt_id}, 0);
    cyc(1);
    chk("s1_valid_k2", {31'b0, evt_valid}, 0);
    cyc(7);
    btn = '0;
    cyc(3);
    chk_log("s1", 1, 0, 0, 0, 0);

    // 2: all buttons at once
    do_reset();
    evt_ready = 1'b1;
    btn = 4'b1111;
    cyc(12);
    btn = '0;
    cyc(2);
    chk_log("s2", 4, 0, 1, 2, 3);
    chk("s2_overruns", ovr_cnt, 0);

    // 3: back-pressure, second press pends, third overruns
    do_reset();
    for (int p = 0; p < 3; p++) begin
      btn = 4'b0100;
      cyc(1);
      btn = '0;
      if (p == 2) begin
        chk("s3_overrun", {31'b0, overrun}, 1);
        chk("s3_pend", {28'b0, pending}, 32'h4);
        chk("s3_id", {30'b0, evt_id}, 2);
      end
      cyc(2);
    end
    chk("s3_overrun_gone", {31'b0, overrun}, 0);
    evt_ready = 1'b1;
    cyc(6);
    chk_log("s3", 2, 2, 2, 0, 0);
    chk("s3_overruns", ovr_cnt, 1);

    // 4: wrap-around after granting id 2
    do_reset();
    btn = 4'b0100;
    cyc(2);
    btn = 4'b1001;
    cyc(1);
    chk("s4_pend", {28'b0, pending}, 32'h9);
    evt_ready = 1'b1;
    cyc(6);
    btn = '0;
    cyc(2);
    chk_log("s4", 3, 2, 3, 0, 0);

    // 5: reset mid-offer with the button still held
    do_reset();
    btn = 4'b0010;
    cyc(2);
    chk("s5_valid_pre", {31'b0, evt_valid}, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("s5_valid_post", {31'b0, evt_valid}, 0);
    chk("s5_pend_post", {28'b0, pending}, 0);
    chk("s5_ovr_post", {31'b0, overrun}, 0);
    evt_ready = 1'b1;
    cyc(4);
    chk_log("s5_held", 0, 0, 0, 0, 0);
    btn = '0;
    cyc(2);
    btn = 4'b0010;
    cyc(4);
    btn = '0;
    cyc(2);
    chk_log("s5", 1, 1, 0, 0, 0);

    // 6: long hold of btn1
    do_reset();
    evt_ready = 1'b1;
    btn = 4'b0010;
    cyc(20);
    btn = '0;
    cyc(4);
`ifdef BTN_EVT_AUTOREPEAT_EN
    chk_log("s6", 4, 1, 1, 1, 1);
`else
    chk_log("s6", 1, 1, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
